// File: rtl/reg_scoreboard.sv
// Decode-side register scoreboard for long-latency writes.
// Tracks pending rd writes and stalls decode on RAW/WAW/full hazards.
module reg_scoreboard #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_D_valid,
   input  logic [4:0]    i_D_rs1_index,
   input  logic [4:0]    i_D_rs2_index,
   input  logic          i_D_rs1_used,
   input  logic          i_D_rs2_used,
   input  logic [4:0]    i_D_rd_index,
   input  logic          i_D_rd_we,
   input  logic          i_D_long,
   input  logic          i_hold,
   input  logic          i_flush,
   input  logic          i_W_wb_en,
   input  logic [4:0]    i_W_rd_index,
   input  logic          i_W_long,
   output logic          o_stall,
   output logic [31:0]   o_busy,
   output logic [CW-1:0] o_outstanding,
   output logic          o_err,
   output logic [31:0]   o_stall_cycles
);

   logic [31:0]   busy_q;
   logic [31:0]   busy_nxt;
   logic [31:0]   eff_busy;
   logic [31:0]   clr_mask;
   logic [31:0]   set_mask;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] cnt_after;
   logic          comp;
   logic          w_bad;
   logic          raw1;
   logic          raw2;
   logic          waw;
   logic          full;
   logic          issue_long;
   logic          rd_nz;

   assign rd_nz = (i_D_rd_index != 5'd0);

   assign comp = i_W_wb_en & i_W_long & (i_W_rd_index != 5'd0)
               & busy_q[i_W_rd_index];

   assign w_bad = i_W_wb_en & i_W_long
                & ((i_W_rd_index == 5'd0) | ~busy_q[i_W_rd_index]);

   assign clr_mask = comp ? (32'd1 << i_W_rd_index) : 32'd0;

   // A retiring write is forwarded by the register file, so it is not a hazard
   assign eff_busy = busy_q & ~clr_mask;

   assign raw1 = i_D_rs1_used & (i_D_rs1_index != 5'd0)
               & eff_busy[i_D_rs1_index];
   assign raw2 = i_D_rs2_used & (i_D_rs2_index != 5'd0)
               & eff_busy[i_D_rs2_index];
   assign waw  = i_D_rd_we & rd_nz & eff_busy[i_D_rd_index];

   assign cnt_after = o_outstanding - CW'(comp);
   assign full = i_D_rd_we & i_D_long & rd_nz
               & (cnt_after == CW'(MAX_OUTSTANDING));

   assign o_stall = i_D_valid & ~i_flush & (raw1 | raw2 | waw | full);

   assign issue_long = i_D_valid & ~i_flush & ~i_hold & ~o_stall
                     & i_D_rd_we & i_D_long & rd_nz;

   assign set_mask = issue_long ? (32'd1 << i_D_rd_index) : 32'd0;

   always_comb begin
      busy_nxt = (busy_q & ~clr_mask) | set_mask;
      busy_nxt[0] = 1'b0;
      cnt_nxt = o_outstanding + CW'(issue_long) - CW'(comp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q         <= 32'd0;
         o_outstanding  <= '0;
         o_err          <= 1'b0;
         o_stall_cycles <= 32'd0;
      end else begin
         busy_q        <= busy_nxt;
         o_outstanding <= cnt_nxt;
         if (w_bad)
            o_err <= 1'b1;
         if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF))
            o_stall_cycles <= o_stall_cycles + 32'd1;
      end
   end

   assign o_busy = busy_q;

endmodule
